// File: rtl/dpwm_pkg.sv
// Shared types and defaults for the complementary DPWM block.
package dpwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int DPWM_CNT_W    = 10;
  localparam int DPWM_DT_W     = 4;
  localparam int DPWM_SS_DIV_W = 8;
  localparam int PERIOD_MIN    = 2;

endpackage

// File: rtl/dpwm_deadtime.sv
// Rising-edge dead-time insertion for one gate; falling edges pass straight through.
module dpwm_deadtime #(
  parameter int DT_W = dpwm_pkg::DPWM_DT_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            raw,
  input  logic [DT_W-1:0] dt,
  output logic            gate
);

  logic            raw_q;
  logic [DT_W-1:0] dcnt;

  // gate rises dt clk after the registered raw rise; any raw low kills it at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw_q <= 1'b0;
      dcnt  <= '0;
      gate  <= 1'b0;
    end else begin
      raw_q <= raw;
      if (!raw) begin
        gate <= 1'b0;
        dcnt <= '0;
      end else if (!raw_q) begin
        gate <= (dt == '0);
        dcnt <= (dt == '0) ? '0 : dt - 1'b1;
      end else if (!gate) begin
        if (dcnt == '0) gate <= 1'b1;
        else            dcnt <= dcnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpwm_cplx_ss.sv
// Complementary sawtooth DPWM with period-boundary shadows, dead time and soft-start ramp.
module dpwm_cplx_ss
  import dpwm_pkg::*;
#(
  parameter int CNT_W    = DPWM_CNT_W,
  parameter int DT_W     = DPWM_DT_W,
  parameter int SS_DIV_W = DPWM_SS_DIV_W,
  parameter int SS_STEP  = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic                ss_en,
  input  logic [CNT_W-1:0]    period,
  input  logic [CNT_W-1:0]    duty,
  input  logic [DT_W-1:0]     dt_hs,
  input  logic [DT_W-1:0]     dt_ls,
  input  logic [SS_DIV_W-1:0] ss_div,
  output logic                hs_gate,
  output logic                ls_gate,
  output logic                cyc_start,
  output logic                ss_done,
  output logic [CNT_W-1:0]    duty_eff
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_sh, period_d, duty_sh, duty_d;
  logic [CNT_W-1:0]    duty_eff_q, duty_eff_d, duty_app;
  logic [DT_W-1:0]     dt_hs_sh, dt_hs_d, dt_ls_sh, dt_ls_d;
  logic [SS_DIV_W-1:0] ss_cnt_q, ss_cnt_d, ss_lim;
  logic [SS_DIV_W:0]   ss_nxt;
  logic [CNT_W-1:0]    period_new, duty_new;
  logic [CNT_W:0]      duty_lim, step_sum;
  logic                wrap, load_sh, ss_step, active, hs_cmp;

  // Clamped candidates for the next shadow load; duty limit needs one extra bit
  always_comb begin
    period_new = (period < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : period;
    duty_lim   = {1'b0, period_new} + 1'b1;
    duty_new   = ({1'b0, duty} > duty_lim) ? duty_lim[CNT_W-1:0] : duty;
    ss_lim     = (ss_div == '0) ? SS_DIV_W'(1) : ss_div;
    ss_nxt     = {1'b0, ss_cnt_q} + 1'b1;
    ss_step    = (ss_nxt >= {1'b0, ss_lim});
    step_sum   = {1'b0, duty_eff_q} + (CNT_W+1)'(SS_STEP);
    wrap       = (cnt_q == period_sh);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_sh  <= '0;
      duty_sh    <= '0;
      dt_hs_sh   <= '0;
      dt_ls_sh   <= '0;
      duty_eff_q <= '0;
      ss_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_sh  <= period_d;
      duty_sh    <= duty_d;
      dt_hs_sh   <= dt_hs_d;
      dt_ls_sh   <= dt_ls_d;
      duty_eff_q <= duty_eff_d;
      ss_cnt_q   <= ss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_sh;
    duty_d     = duty_sh;
    dt_hs_d    = dt_hs_sh;
    dt_ls_d    = dt_ls_sh;
    duty_eff_d = duty_eff_q;
    ss_cnt_d   = ss_cnt_q;
    load_sh    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        duty_eff_d = '0;
        ss_cnt_d   = '0;
        if (en) begin
          load_sh = 1'b1;
          state_d = ss_en ? RAMP : RUN;
        end
      end
      RAMP, RUN: begin
        if (!wrap) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          load_sh = 1'b1;
          // ramp is judged against the target that applies to the coming period
          if (state_q == RAMP) begin
            if (duty_new < duty_eff_q) begin
              duty_eff_d = duty_new;
              state_d    = RUN;
            end else if (ss_step) begin
              ss_cnt_d = '0;
              if (step_sum >= {1'b0, duty_new}) begin
                duty_eff_d = duty_new;
                state_d    = RUN;
              end else begin
                duty_eff_d = step_sum[CNT_W-1:0];
              end
            end else begin
              ss_cnt_d = ss_nxt[SS_DIV_W-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_sh) begin
      period_d = period_new;
      duty_d   = duty_new;
      dt_hs_d  = dt_hs;
      dt_ls_d  = dt_ls;
    end
    if (!en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      duty_eff_d = '0;
      ss_cnt_d   = '0;
    end
  end

  // In RUN the applied duty is the shadow itself; the ramp register only matters in RAMP
  assign duty_app  = (state_q == RUN) ? duty_sh : duty_eff_q;
  assign duty_eff  = duty_app;
  assign active    = (state_q != IDLE) && en;
  assign hs_cmp    = (cnt_q < duty_app);
  assign cyc_start = (state_q != IDLE) && (cnt_q == '0);
  assign ss_done   = (state_q == RUN);

  dpwm_deadtime #(.DT_W(DT_W)) u_dt_hs (
    .clk    (clk),
    .resetn (resetn),
    .raw    (active && hs_cmp),
    .dt     (dt_hs_sh),
    .gate   (hs_gate)
  );

  dpwm_deadtime #(.DT_W(DT_W)) u_dt_ls (
    .clk    (clk),
    .resetn (resetn),
    .raw    (active && !hs_cmp),
    .dt     (dt_ls_sh),
    .gate   (ls_gate)
  );

endmodule
